// File: rtl/acsp_pkg.sv
//------------------------------------------------------------------------------
// Module   : acsp_pkg
// Brief    : Shared types and constants for the analyzer serial command protocol.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acsp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } enc_state_t;

  localparam int LONG_CMD_BIT  = 7;
  localparam int CMD_ARG_BYTES = 4;

  localparam logic [7:0] OP_RESET       = 8'h00;
  localparam logic [7:0] OP_RUN         = 8'h01;
  localparam logic [7:0] OP_ID          = 8'h02;
  localparam logic [7:0] OP_SET_DIVIDER = 8'h80;
  localparam logic [7:0] OP_SET_COUNTS  = 8'h81;

endpackage

`default_nettype wire

// File: rtl/command_encoder.sv
//------------------------------------------------------------------------------
// Module   : command_encoder
// Brief    : Serializes one opcode (+ optional 32-bit argument) into UART bytes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module command_encoder #(
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_opcode,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        enc_busy,
  output logic        cmd_done
);
  import acsp_pkg::*;

  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_LONG    = 3'(CMD_ARG_BYTES);

  enc_state_t       state_q, state_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_q, op_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_start_q, tx_start_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             enc_busy_q, enc_busy_d;
  logic             cmd_done_q, cmd_done_d;
  logic [2:0]       last_idx;
  logic [7:0]       sel_byte;

  assign last_idx = op_q[LONG_CMD_BIT] ? LAST_LONG : 3'd0;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    data_d      = data_q;
    tx_start_d  = 1'b0;
    cmd_done_d  = 1'b0;
    // cmd_ready lags the return to IDLE by one cycle so it rises after cmd_done
    cmd_ready_d = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_opcode;
          data_d      = cmd_data;
          byte_idx_d  = 3'd0;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (byte_idx_q == last_idx) begin
            cmd_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (byte_idx_d)
      3'd0:    sel_byte = op_d;
      3'd1:    sel_byte = data_d[7:0];
      3'd2:    sel_byte = data_d[15:8];
      3'd3:    sel_byte = data_d[23:16];
      3'd4:    sel_byte = data_d[31:24];
      default: sel_byte = 8'h00;
    endcase

    // tx_byte only changes on entry to LOAD, so it is stable until busy falls
    tx_byte_d  = (state_d == LOAD) ? sel_byte : tx_byte_q;
    enc_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_idx_q  <= 3'd0;
      cnt_q       <= '0;
      op_q        <= 8'h00;
      data_q      <= 32'h0;
      tx_byte_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      enc_busy_q  <= 1'b0;
      cmd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      tx_byte_q   <= tx_byte_d;
      tx_start_q  <= tx_start_d;
      cmd_ready_q <= cmd_ready_d;
      enc_busy_q  <= enc_busy_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tx_byte   = tx_byte_q;
  assign tx_start  = tx_start_q;
  assign enc_busy  = enc_busy_q;
  assign cmd_done  = cmd_done_q;

endmodule

`default_nettype wire

// File: tb/tb_command_encoder.sv
//------------------------------------------------------------------------------
// Module   : tb_command_encoder
// Brief    : Scoreboard bench for command_encoder with a simple UART busy model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_command_encoder;

  localparam int BUSY_TIMEOUT = 16;
  localparam int GAP_CYCLES   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_opcode = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_ready;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic        enc_busy;
  logic        cmd_done;

  command_encoder #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_opcode(cmd_opcode),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .enc_busy  (enc_busy),
    .cmd_done  (cmd_done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // UART model: busy for busy_len cycles after a tx_start; unaffected by reset
  int   busy_len = 10;
  logic uart_en = 1'b1;
  logic hold_busy = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clock) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start && uart_en) busy_cnt <= busy_len;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  logic [7:0] exp_q[$];
  int   start_cnt = 0;
  int   done_cnt = 0;
  int   last_done_cyc = -1;
  int   fall_cyc = 0;
  logic fell_valid = 1'b0;
  logic prev_busy = 1'b0;
  logic chk_gap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [31:0] data);
    exp_q.push_back(op);
    if (op[7]) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(data[8*i +: 8]);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (prev_busy && !tx_busy) begin
        fall_cyc   = cyc;
        fell_valid = 1'b1;
      end
      prev_busy = tx_busy;
      if (tx_start) begin
        start_cnt++;
        check("start_while_busy", {31'd0, tx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, tx_byte}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
        end
        // busy-low cycle seen by WAIT_LO, then GAP_CYCLES of GAP, then LOAD
        if (chk_gap && fell_valid) check("gap_after_busy", cyc - fall_cyc, GAP_CYCLES + 2);
        fell_valid = 1'b0;
      end
      if (cmd_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        fell_valid    = 1'b0;
      end
    end
  end

  task automatic drive_cmd(input logic [7:0] op, input logic [31:0] data);
    cmd_opcode = op;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    push_cmd(op, data);
  endtask

  task automatic wait_accept(output int acc);
    logic got;
    got = 1'b0;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        got = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        break;
      end
      @(negedge clock);
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_start(output int at);
    logic got;
    got = 1'b0;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        at  = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int at);
    logic got;
    got = 1'b0;
    at = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (cmd_done === 1'b1) begin
        at  = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    int acc, acc2, st, dn, s0, d0;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
    check("rst_enc_busy", {31'd0, enc_busy}, 32'd0);
    check("rst_cmd_done", {31'd0, cmd_done}, 32'd0);

    // Short command
    s0 = start_cnt; d0 = done_cnt;
    drive_cmd(8'h01, 32'hDEAD_BEEF);
    wait_accept(acc);
    wait_start(st);
    check("short_latency", st - acc, 32'd2);
    wait_done(dn);
    check("short_ready_at_done", {31'd0, cmd_ready}, 32'd0);
    check("short_starts", start_cnt - s0, 32'd1);
    check("short_dones", done_cnt - d0, 32'd1);
    @(negedge clock);
    check("short_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Long command with gap timing checks
    chk_gap = 1'b1;
    s0 = start_cnt; d0 = done_cnt;
    drive_cmd(8'h80, 32'h0000_1234);
    wait_accept(acc);
    wait_done(dn);
    check("long_starts", start_cnt - s0, 32'd5);
    check("long_dones", done_cnt - d0, 32'd1);
    check("long_queue_empty", exp_q.size(), 32'd0);

    // Busy timeout: UART never answers
    @(negedge clock);
    uart_en = 1'b0;
    s0 = start_cnt;
    drive_cmd(8'h02, 32'h0);
    wait_accept(acc);
    wait_start(st);
    wait_done(dn);
    check("timeout_done_cycle", dn - st, BUSY_TIMEOUT + GAP_CYCLES);
    check("timeout_starts", start_cnt - s0, 32'd1);
    uart_en = 1'b1;

    // Back-to-back with cmd_valid held for the second command
    @(negedge clock);
    s0 = start_cnt; d0 = done_cnt;
    drive_cmd(8'h81, 32'hAABB_CCDD);
    wait_accept(acc);
    drive_cmd(8'h00, 32'h0);
    wait_accept(acc2);
    #1;
    check("b2b_accept_after_done", acc2 - last_done_cyc, 32'd1);
    wait_done(dn);
    check("b2b_starts", start_cnt - s0, 32'd6);
    check("b2b_dones", done_cnt - d0, 32'd2);
    check("b2b_queue_empty", exp_q.size(), 32'd0);
    chk_gap = 1'b0;

    // Reset during WAIT_LO of byte index 2 of a long command
    @(negedge clock);
    d0 = done_cnt;
    drive_cmd(8'h80, 32'hCAFE_BABE);
    wait_accept(acc);
    for (int n = 0; n < 3; n++) wait_start(st);
    for (int i = 0; i < 20 && tx_busy !== 1'b1; i++) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midrst_enc_busy", {31'd0, enc_busy}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_pending", exp_q.size(), 32'd2);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check("midrst_no_done", done_cnt - d0, 32'd0);
    s0 = start_cnt;
    @(negedge clock);
    drive_cmd(8'h00, 32'h0);
    wait_accept(acc);
    wait_done(dn);
    check("postrst_starts", start_cnt - s0, 32'd1);
    check("postrst_dones", done_cnt - d0, 32'd1);

    // Stall: tx_busy already high when LOAD is entered
    @(negedge clock);
    hold_busy = 1'b1;
    s0 = start_cnt;
    drive_cmd(8'h01, 32'h0);
    wait_accept(acc);
    repeat (6) begin
      @(negedge clock);
      check("stall_no_start", {31'd0, tx_start}, 32'd0);
      check("stall_byte_stable", {24'd0, tx_byte}, 32'h01);
    end
    hold_busy = 1'b0;
    wait_start(st);
    check("stall_byte_at_start", {24'd0, tx_byte}, 32'h01);
    wait_done(dn);
    check("stall_starts", start_cnt - s0, 32'd1);
    check("stall_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
